// File: rtl/axi_read_arbiter_pkg.sv
// Shared AXI widths and the arbiter FSM encoding, common to the read and write bridge arbiters.
package axi_read_arbiter_pkg;

    localparam int AXI_IDM_BITS  = 4;
    localparam int AXI_IDS_BITS  = 8;
    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter2.sv
// Two-requester combinational pick; prio names the winner when both request.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (req == 2'b11) begin
            grant = prio;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one downstream AXI read path between M0 and M1, one transaction at a time,
// with round-robin AR arbitration and the master index carried in the upper ARID bits.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int IDM_W  = AXI_IDM_BITS,
    parameter int IDS_W  = AXI_IDS_BITS,
    parameter int ADDR_W = AXI_ADDR_BITS,
    parameter int DATA_W = AXI_DATA_BITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDM_W-1:0]  ARID_M0,
    input  logic [IDM_W-1:0]  ARID_M1,
    input  logic [ADDR_W-1:0] ARADDR_M0,
    input  logic [ADDR_W-1:0] ARADDR_M1,
    input  logic [3:0]        ARLEN_M0,
    input  logic [3:0]        ARLEN_M1,
    input  logic [2:0]        ARSIZE_M0,
    input  logic [2:0]        ARSIZE_M1,
    input  logic [1:0]        ARBURST_M0,
    input  logic [1:0]        ARBURST_M1,
    input  logic              ARVALID_M0,
    input  logic              ARVALID_M1,
    output logic              ARREADY_M0,
    output logic              ARREADY_M1,
    output logic [IDS_W-1:0]  ARID_S,
    output logic [ADDR_W-1:0] ARADDR_S,
    output logic [3:0]        ARLEN_S,
    output logic [2:0]        ARSIZE_S,
    output logic [1:0]        ARBURST_S,
    output logic              ARVALID_S,
    input  logic              ARREADY_S,
    input  logic [IDS_W-1:0]  RID_S,
    input  logic [DATA_W-1:0] RDATA_S,
    input  logic [1:0]        RRESP_S,
    input  logic              RLAST_S,
    input  logic              RVALID_S,
    output logic              RREADY_S,
    output logic [IDM_W-1:0]  RID_M0,
    output logic [IDM_W-1:0]  RID_M1,
    output logic [DATA_W-1:0] RDATA_M0,
    output logic [DATA_W-1:0] RDATA_M1,
    output logic [1:0]        RRESP_M0,
    output logic [1:0]        RRESP_M1,
    output logic              RLAST_M0,
    output logic              RLAST_M1,
    output logic              RVALID_M0,
    output logic              RVALID_M1,
    input  logic              RREADY_M0,
    input  logic              RREADY_M1
);

    arb_state_e state_q, state_d;
    logic       grant_q, grant_d;
    logic       prio_q, prio_d;
    logic       arb_grant;
    logic       in_addr, in_data;
    logic [IDM_W-1:0] arid_g;

    rr_arbiter2 u_rr_arbiter2 (
        .req   ({ARVALID_M1, ARVALID_M0}),
        .prio  (prio_q),
        .grant (arb_grant)
    );

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);

    // AR channel: fields follow the registered grant, handshake only while in ADDR.
    assign arid_g     = grant_q ? ARID_M1 : ARID_M0;
    assign ARID_S     = {(IDS_W-IDM_W)'(grant_q), arid_g};
    assign ARADDR_S   = grant_q ? ARADDR_M1  : ARADDR_M0;
    assign ARLEN_S    = grant_q ? ARLEN_M1   : ARLEN_M0;
    assign ARSIZE_S   = grant_q ? ARSIZE_M1  : ARSIZE_M0;
    assign ARBURST_S  = grant_q ? ARBURST_M1 : ARBURST_M0;
    assign ARVALID_S  = in_addr & (grant_q ? ARVALID_M1 : ARVALID_M0);
    assign ARREADY_M0 = in_addr & ~grant_q & ARREADY_S;
    assign ARREADY_M1 = in_addr &  grant_q & ARREADY_S;

    // R channel: payload is broadcast, valid/ready are routed by grant, not by RID_S.
    assign RID_M0    = RID_S[IDM_W-1:0];
    assign RID_M1    = RID_S[IDM_W-1:0];
    assign RDATA_M0  = RDATA_S;
    assign RDATA_M1  = RDATA_S;
    assign RRESP_M0  = RRESP_S;
    assign RRESP_M1  = RRESP_S;
    assign RLAST_M0  = RLAST_S;
    assign RLAST_M1  = RLAST_S;
    assign RVALID_M0 = in_data & ~grant_q & RVALID_S;
    assign RVALID_M1 = in_data &  grant_q & RVALID_S;
    assign RREADY_S  = in_data & (grant_q ? RREADY_M1 : RREADY_M0);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (ARVALID_M0 || ARVALID_M1) begin
                    grant_d = arb_grant;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (ARVALID_S && ARREADY_S) begin
                    state_d = DATA;
                    prio_d  = ~grant_q;
                end
            end
            DATA: begin
                if (RVALID_S && RREADY_S && RLAST_S) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            prio_q  <= prio_d;
        end
    end

    a_state_legal: assert property (@(posedge clk) disable iff (rst)
        state_q inside {IDLE, ADDR, DATA});
    a_rvalid_onehot: assert property (@(posedge clk) disable iff (rst)
        !(RVALID_M0 && RVALID_M1));
    a_arvalid_addr_only: assert property (@(posedge clk) disable iff (rst)
        ARVALID_S |-> (state_q == ADDR));
    a_rid_master: assert property (@(posedge clk) disable iff (rst)
        (in_data && RVALID_S) |-> (RID_S[IDS_W-1:IDM_W] == (IDS_W-IDM_W)'(grant_q)));

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: arbitration, alternation, bursts, stalls and reset.
module tb_axi_read_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  arid_m0, arid_m1;
    logic [31:0] araddr_m0, araddr_m1;
    logic [3:0]  arlen_m0, arlen_m1;
    logic [2:0]  arsize_m0, arsize_m1;
    logic [1:0]  arburst_m0, arburst_m1;
    logic        arvalid_m0, arvalid_m1;
    logic        arready_m0, arready_m1;
    logic [7:0]  arid_s;
    logic [31:0] araddr_s;
    logic [3:0]  arlen_s;
    logic [2:0]  arsize_s;
    logic [1:0]  arburst_s;
    logic        arvalid_s;
    logic        arready_s;
    logic [7:0]  rid_s;
    logic [31:0] rdata_s;
    logic [1:0]  rresp_s;
    logic        rlast_s, rvalid_s, rready_s;
    logic [3:0]  rid_m0, rid_m1;
    logic [31:0] rdata_m0, rdata_m1;
    logic [1:0]  rresp_m0, rresp_m1;
    logic        rlast_m0, rlast_m1;
    logic        rvalid_m0, rvalid_m1;
    logic        rready_m0, rready_m1;

    int total = 0;
    int bad   = 0;

    axi_read_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .ARID_M0    (arid_m0),
        .ARID_M1    (arid_m1),
        .ARADDR_M0  (araddr_m0),
        .ARADDR_M1  (araddr_m1),
        .ARLEN_M0   (arlen_m0),
        .ARLEN_M1   (arlen_m1),
        .ARSIZE_M0  (arsize_m0),
        .ARSIZE_M1  (arsize_m1),
        .ARBURST_M0 (arburst_m0),
        .ARBURST_M1 (arburst_m1),
        .ARVALID_M0 (arvalid_m0),
        .ARVALID_M1 (arvalid_m1),
        .ARREADY_M0 (arready_m0),
        .ARREADY_M1 (arready_m1),
        .ARID_S     (arid_s),
        .ARADDR_S   (araddr_s),
        .ARLEN_S    (arlen_s),
        .ARSIZE_S   (arsize_s),
        .ARBURST_S  (arburst_s),
        .ARVALID_S  (arvalid_s),
        .ARREADY_S  (arready_s),
        .RID_S      (rid_s),
        .RDATA_S    (rdata_s),
        .RRESP_S    (rresp_s),
        .RLAST_S    (rlast_s),
        .RVALID_S   (rvalid_s),
        .RREADY_S   (rready_s),
        .RID_M0     (rid_m0),
        .RID_M1     (rid_m1),
        .RDATA_M0   (rdata_m0),
        .RDATA_M1   (rdata_m1),
        .RRESP_M0   (rresp_m0),
        .RRESP_M1   (rresp_m1),
        .RLAST_M0   (rlast_m0),
        .RLAST_M1   (rlast_m1),
        .RVALID_M0  (rvalid_m0),
        .RVALID_M1  (rvalid_m1),
        .RREADY_M0  (rready_m0),
        .RREADY_M1  (rready_m1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        arid_m0 = '0; arid_m1 = '0; araddr_m0 = '0; araddr_m1 = '0;
        arlen_m0 = '0; arlen_m1 = '0; arsize_m0 = '0; arsize_m1 = '0;
        arburst_m0 = '0; arburst_m1 = '0; arvalid_m0 = 1'b0; arvalid_m1 = 1'b0;
        arready_s = 1'b0; rid_s = '0; rdata_s = '0; rresp_s = '0;
        rlast_s = 1'b0; rvalid_s = 1'b0; rready_m0 = 1'b0; rready_m1 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        arvalid_m0 = 1'b1; arvalid_m1 = 1'b1; arready_s = 1'b1;
        rvalid_s = 1'b1; rlast_s = 1'b1; rready_m0 = 1'b1; rready_m1 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            total++;
            if ({arready_m0, arready_m1, arvalid_s, rvalid_m0, rvalid_m1, rready_s} !== 6'b0) begin
                bad++;
                $display("FAIL reset_outs: got %b want 000000",
                         {arready_m0, arready_m1, arvalid_s, rvalid_m0, rvalid_m1, rready_s});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        $display("txn reset: outputs checked while rst held");
    endtask

    task automatic test_single();
        @(negedge clk);
        arvalid_m0 = 1'b1; arid_m0 = 4'h3; araddr_m0 = 32'h0001_0000; arlen_m0 = 4'd0;
        arready_s = 1'b1;
        #1;
        total++;
        if (arvalid_s !== 1'b0) begin bad++; $display("FAIL single_arb_cycle: arvalid_s=%b want 0", arvalid_s); end
        @(negedge clk); #1;
        total++;
        if ({arvalid_s, arid_s, araddr_s} !== {1'b1, 8'h03, 32'h0001_0000}) begin
            bad++; $display("FAIL single_ar: valid=%b id=%h addr=%h want 1 03 00010000", arvalid_s, arid_s, araddr_s);
        end
        total++;
        if ({arready_m0, arready_m1} !== 2'b10) begin bad++; $display("FAIL single_arready: got %b want 10", {arready_m0, arready_m1}); end
        @(negedge clk);
        arvalid_m0 = 1'b0; rvalid_s = 1'b1; rlast_s = 1'b1; rid_s = 8'h03;
        rdata_s = 32'hCAFE_0001; rresp_s = 2'b10; rready_m0 = 1'b1;
        #1;
        total++;
        if ({rvalid_m0, rvalid_m1, rready_s} !== 3'b101) begin bad++; $display("FAIL single_rvalid: got %b want 101", {rvalid_m0, rvalid_m1, rready_s}); end
        total++;
        if ({rid_m0, rdata_m0, rresp_m0, rresp_m1, rlast_m0} !== {4'h3, 32'hCAFE_0001, 2'b10, 2'b10, 1'b1}) begin
            bad++; $display("FAIL single_rpayload: id=%h data=%h resp=%b/%b last=%b", rid_m0, rdata_m0, rresp_m0, rresp_m1, rlast_m0);
        end
        @(negedge clk); #1;
        total++;
        if ({rvalid_m0, rready_s} !== 2'b00) begin bad++; $display("FAIL single_release: got %b want 00", {rvalid_m0, rready_s}); end
        clear_inputs();
        $display("txn single: M0 id=3 addr=00010000 len=0");
    endtask

    task automatic test_tie();
        do_reset();
        @(negedge clk);
        arvalid_m0 = 1'b1; arvalid_m1 = 1'b1; arid_m0 = 4'h5; arid_m1 = 4'hA;
        araddr_m0 = 32'h100; araddr_m1 = 32'h200; arready_s = 1'b1;
        #1;
        total++;
        if (arvalid_s !== 1'b0) begin bad++; $display("FAIL tie_arb_cycle: arvalid_s=%b want 0", arvalid_s); end
        @(negedge clk); #1;
        total++;
        if ({arid_s, araddr_s, arready_m0, arready_m1} !== {8'h05, 32'h100, 2'b10}) begin
            bad++; $display("FAIL tie_first_m0: id=%h addr=%h rdy=%b want 05 100 10", arid_s, araddr_s, {arready_m0, arready_m1});
        end
        @(negedge clk);
        arvalid_m0 = 1'b0; rvalid_s = 1'b1; rlast_s = 1'b1; rid_s = 8'h05;
        rready_m0 = 1'b1; rready_m1 = 1'b1;
        #1;
        total++;
        if ({rvalid_m0, rvalid_m1, arready_m1} !== 3'b100) begin bad++; $display("FAIL tie_r_m0: got %b want 100", {rvalid_m0, rvalid_m1, arready_m1}); end
        @(negedge clk);
        rvalid_s = 1'b0;
        #1;
        total++;
        if (arvalid_s !== 1'b0) begin bad++; $display("FAIL tie_bubble: arvalid_s=%b want 0", arvalid_s); end
        @(negedge clk); #1;
        total++;
        if ({arid_s, araddr_s, arready_m0, arready_m1} !== {8'h1A, 32'h200, 2'b01}) begin
            bad++; $display("FAIL tie_second_m1: id=%h addr=%h rdy=%b want 1a 200 01", arid_s, araddr_s, {arready_m0, arready_m1});
        end
        @(negedge clk);
        arvalid_m1 = 1'b0; rvalid_s = 1'b1; rid_s = 8'h1A;
        #1;
        total++;
        if ({rvalid_m0, rvalid_m1, rid_m1} !== {2'b01, 4'hA}) begin
            bad++; $display("FAIL tie_r_m1: valid=%b id=%h want 01 a", {rvalid_m0, rvalid_m1}, rid_m1);
        end
        @(negedge clk);
        clear_inputs();
        $display("txn tie: M0 id=5 then M1 id=a");
    endtask

    task automatic test_alternation();
        logic       exp_m;
        logic [7:0] exp_id;
        arid_m0 = 4'h1; arid_m1 = 4'h2; arready_s = 1'b1;
        rready_m0 = 1'b1; rready_m1 = 1'b1; rlast_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_m  = i[0];
            exp_id = exp_m ? 8'h12 : 8'h01;
            @(negedge clk);
            arvalid_m0 = 1'b1; arvalid_m1 = 1'b1; rvalid_s = 1'b0;
            #1;
            total++;
            if (arvalid_s !== 1'b0) begin bad++; $display("FAIL alt_idle[%0d]: arvalid_s=%b want 0", i, arvalid_s); end
            @(negedge clk); #1;
            total++;
            if (arid_s !== exp_id) begin bad++; $display("FAIL alt_grant[%0d]: arid_s=%h want %h", i, arid_s, exp_id); end
            @(negedge clk);
            rvalid_s = 1'b1; rid_s = exp_id;
            #1;
            total++;
            if ({rvalid_m1, rvalid_m0} !== (exp_m ? 2'b10 : 2'b01)) begin
                bad++; $display("FAIL alt_route[%0d]: {m1,m0}=%b want %b", i, {rvalid_m1, rvalid_m0}, exp_m ? 2'b10 : 2'b01);
            end
            $display("txn alternation[%0d]: expected master M%0d", i, exp_m);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_burst();
        int beats;
        @(negedge clk);
        arvalid_m1 = 1'b1; arid_m1 = 4'h7; arlen_m1 = 4'd3; araddr_m1 = 32'h3000; arready_s = 1'b1;
        @(negedge clk); #1;
        total++;
        if ({arlen_s, arid_s} !== {4'd3, 8'h17}) begin bad++; $display("FAIL burst_ar: len=%0d id=%h want 3 17", arlen_s, arid_s); end
        beats = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            arvalid_m1 = 1'b0; rvalid_s = 1'b1; rid_s = 8'h17;
            rready_m1 = ~c[0];
            rlast_s = (beats == 3);
            rdata_s = 32'(beats);
            #1;
            total++;
            if ({rvalid_m1, rvalid_m0} !== {(c < 7), 1'b0}) begin
                bad++; $display("FAIL burst_rvalid[c%0d]: {m1,m0}=%b want %b", c, {rvalid_m1, rvalid_m0}, {(c < 7), 1'b0});
            end
            if (c < 7) begin
                total++;
                if ({rready_s, rdata_m1, rlast_m1} !== {rready_m1, 32'(beats), (beats == 3)}) begin
                    bad++; $display("FAIL burst_beat[c%0d]: rready_s=%b data=%h last=%b", c, rready_s, rdata_m1, rlast_m1);
                end
            end
            if (rvalid_m1 && rready_s) beats++;
        end
        total++;
        if (beats !== 4) begin bad++; $display("FAIL burst_count: beats=%0d want 4", beats); end
        clear_inputs();
        $display("txn burst: M1 id=7 len=3 beats=%0d", beats);
    endtask

    task automatic test_stall();
        @(negedge clk);
        arvalid_m0 = 1'b1; arid_m0 = 4'h9; araddr_m0 = 32'hDEAD_BEE0;
        arlen_m0 = 4'd2; arsize_m0 = 3'd2; arburst_m0 = 2'd1; arready_s = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            total++;
            if ({arvalid_s, araddr_s, arid_s, arlen_s, arsize_s, arburst_s, arready_m0} !==
                {1'b1, 32'hDEAD_BEE0, 8'h09, 4'd2, 3'd2, 2'd1, 1'b0}) begin
                bad++; $display("FAIL stall_hold[%0d]: v=%b addr=%h id=%h len=%0d size=%0d burst=%0d rdy=%b",
                                k, arvalid_s, araddr_s, arid_s, arlen_s, arsize_s, arburst_s, arready_m0);
            end
        end
        @(negedge clk);
        arready_s = 1'b1;
        #1;
        total++;
        if ({arvalid_s, arready_m0} !== 2'b11) begin bad++; $display("FAIL stall_release: got %b want 11", {arvalid_s, arready_m0}); end
        @(negedge clk);
        arvalid_m0 = 1'b0; rvalid_s = 1'b1; rlast_s = 1'b1; rid_s = 8'h09; rready_m0 = 1'b1;
        #1;
        total++;
        if (rvalid_m0 !== 1'b1) begin bad++; $display("FAIL stall_r: rvalid_m0=%b want 1", rvalid_m0); end
        @(negedge clk);
        clear_inputs();
        $display("txn stall: M0 id=9 addr=deadbee0 after 5 stall cycles");
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        arvalid_m0 = 1'b1; arid_m0 = 4'h4; arlen_m0 = 4'd3; arready_s = 1'b1;
        @(negedge clk); #1;
        total++;
        if (arvalid_s !== 1'b1) begin bad++; $display("FAIL midrst_ar: arvalid_s=%b want 1", arvalid_s); end
        @(negedge clk);
        arvalid_m0 = 1'b0; rvalid_s = 1'b1; rid_s = 8'h04; rlast_s = 1'b0; rready_m0 = 1'b1;
        @(negedge clk); #1;
        total++;
        if (rvalid_m0 !== 1'b1) begin bad++; $display("FAIL midrst_beat2: rvalid_m0=%b want 1", rvalid_m0); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({arready_m0, arready_m1, arvalid_s, rvalid_m0, rvalid_m1, rready_s} !== 6'b0) begin
            bad++; $display("FAIL midrst_outs: got %b want 000000",
                            {arready_m0, arready_m1, arvalid_s, rvalid_m0, rvalid_m1, rready_s});
        end
        rvalid_s = 1'b0; arvalid_m1 = 1'b1; arid_m1 = 4'h6;
        @(negedge clk); #1;
        total++;
        if ({arvalid_s, arid_s, arready_m0, arready_m1} !== {1'b1, 8'h16, 2'b01}) begin
            bad++; $display("FAIL midrst_m1_grant: v=%b id=%h rdy=%b want 1 16 01", arvalid_s, arid_s, {arready_m0, arready_m1});
        end
        @(negedge clk);
        arvalid_m1 = 1'b0; rvalid_s = 1'b1; rlast_s = 1'b1; rid_s = 8'h16; rready_m1 = 1'b1;
        #1;
        total++;
        if ({rvalid_m0, rvalid_m1} !== 2'b01) begin bad++; $display("FAIL midrst_m1_r: got %b want 01", {rvalid_m0, rvalid_m1}); end
        @(negedge clk);
        clear_inputs();
        $display("txn mid_reset: M0 abandoned, M1 id=6 served");
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_alternation();
        test_burst();
        test_stall();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
